// File: rtl/mesm6_arb_pkg.sv
// mesm6_arb_pkg
// Shared types for the mesm6 main-memory arbiter:
//   arb_state_t : arbiter FSM states (idle / bus cycle in flight / done pulse)
//   req_id_t    : requester identifiers, also the round-robin order
//   ARB_NREQ    : number of requesters
//   next_req()  : successor of a requester in round-robin order
package mesm6_arb_pkg;

    localparam int ARB_NREQ = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // Encoding order is the round-robin order: dbus -> ibus -> ext -> dbus.
    typedef enum logic [1:0] {
        REQ_DBUS = 2'd0,
        REQ_IBUS = 2'd1,
        REQ_EXT  = 2'd2
    } req_id_t;

    function automatic req_id_t next_req(input req_id_t id);
        case (id)
            REQ_DBUS: return REQ_IBUS;
            REQ_IBUS: return REQ_EXT;
            default:  return REQ_DBUS;
        endcase
    endfunction

endpackage

// File: rtl/mesm6_rr_pick.sv
// mesm6_rr_pick
// Combinational 3-way round-robin selector. The search starts at the
// requester following the last granted one and wraps around.
// Ports:
//   req   : in  request vector, indexed by req_id_t
//   last  : in  id of the most recently granted requester
//   grant : out id of the selected requester (== last when nothing is requested)
//   valid : out at least one request is active
module mesm6_rr_pick
    import mesm6_arb_pkg::*;
(
    input  logic [ARB_NREQ-1:0] req,
    input  req_id_t             last,
    output req_id_t             grant,
    output logic                valid
);

    req_id_t cand;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant = last;
        valid = 1'b0;
        cand  = last;
        for (int k = 0; k < ARB_NREQ; k++) begin
            cand = next_req(cand);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// mesm6_mem_arbiter
// Shares one single-ported main-memory interface between the CPU instruction
// bus (ibus), the CPU data bus (dbus) and an external loader/debug port (ext).
// The core side keeps the core's level-request / one-cycle-done handshake.
// Every transaction is IDLE (grant) -> BUS (strobe until mem_ack) -> DONE
// (one-cycle done pulse); requests are not looked at during DONE because the
// core still shows the completed request on that cycle.
//
// Optional feature: define MESM6_ARB_TIMEOUT_EN to abort a BUS phase after
// TIMEOUT cycles without mem_ack (read data forced to 0, sticky bus_error).
//
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   ibus_fetch/addr -> ibus_input/done  : instruction read requester
//   dbus_read/write/addr/output
//                   -> dbus_input/done  : data requester (read+write = write)
//   ext_req/we/addr/wdata
//                   -> ext_rdata/done   : external requester
//   mem_read/write/addr/wdata,
//   mem_rdata/ack                       : memory controller side
//   bus_error                           : sticky timeout flag (timeout build only)
module mesm6_mem_arbiter
    import mesm6_arb_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 48,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ibus_fetch,
    input  logic [ADDR_W-1:0] ibus_addr,
    output logic [DATA_W-1:0] ibus_input,
    output logic              ibus_done,
    input  logic              dbus_read,
    input  logic              dbus_write,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_output,
    output logic [DATA_W-1:0] dbus_input,
    output logic              dbus_done,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef MESM6_ARB_TIMEOUT_EN
    ,
    output logic              bus_error
`endif
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mesm6_mem_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t          state;
    req_id_t             last_id;
    req_id_t             win_id;
    req_id_t             pick_id;
    logic                pick_valid;
    logic [ARB_NREQ-1:0] req_vec;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                timed_out;
    logic [DATA_W-1:0]   bus_data;

    assign req_vec[REQ_DBUS] = dbus_read | dbus_write;
    assign req_vec[REQ_IBUS] = ibus_fetch;
    assign req_vec[REQ_EXT]  = ext_req;

    mesm6_rr_pick u_pick (
        .req   (req_vec),
        .last  (last_id),
        .grant (pick_id),
        .valid (pick_valid)
    );

    // Operation presented by the requester that wins this cycle.
    always_comb begin
        sel_addr  = dbus_addr;
        sel_wdata = dbus_output;
        sel_we    = dbus_write;     // read+write together is a write
        case (pick_id)
            REQ_IBUS: begin
                sel_addr  = ibus_addr;
                sel_wdata = '0;
                sel_we    = 1'b0;
            end
            REQ_EXT: begin
                sel_addr  = ext_addr;
                sel_wdata = ext_wdata;
                sel_we    = ext_we;
            end
            default: ;
        endcase
    end

`ifdef MESM6_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] bus_cnt;

    // bus_cnt counts BUS cycles already spent without an ack; the cycle on
    // which it equals TIMEOUT-1 is the last one allowed.
    assign timed_out = (state == ARB_BUS) && !mem_ack &&
                       (bus_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign bus_data = timed_out ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_id    <= REQ_EXT;      // so dbus wins the first arbitration
            win_id     <= REQ_DBUS;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ibus_input <= '0;
            dbus_input <= '0;
            ext_rdata  <= '0;
            ibus_done  <= 1'b0;
            dbus_done  <= 1'b0;
            ext_done   <= 1'b0;
`ifdef MESM6_ARB_TIMEOUT_EN
            bus_cnt    <= '0;
            bus_error  <= 1'b0;
`endif
        end else begin
            // NOTE: state and outputs are registers, so they use non-blocking
            // assignments; the done pulses default low every cycle.
            ibus_done <= 1'b0;
            dbus_done <= 1'b0;
            ext_done  <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        win_id    <= pick_id;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_read  <= !sel_we;
                        mem_write <= sel_we;
`ifdef MESM6_ARB_TIMEOUT_EN
                        bus_cnt   <= '0;
`endif
                        state     <= ARB_BUS;
                    end
                end

                ARB_BUS: begin
                    if (mem_ack || timed_out) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        // mem_read still shows the operation type here.
                        if (mem_read) begin
                            case (win_id)
                                REQ_DBUS: dbus_input <= bus_data;
                                REQ_IBUS: ibus_input <= bus_data;
                                default:  ext_rdata  <= bus_data;
                            endcase
                        end
                        case (win_id)
                            REQ_DBUS: dbus_done <= 1'b1;
                            REQ_IBUS: ibus_done <= 1'b1;
                            default:  ext_done  <= 1'b1;
                        endcase
`ifdef MESM6_ARB_TIMEOUT_EN
                        if (timed_out) bus_error <= 1'b1;
`endif
                        last_id <= win_id;
                        state   <= ARB_DONE;
                    end
`ifdef MESM6_ARB_TIMEOUT_EN
                    else begin
                        bus_cnt <= bus_cnt + 1'b1;
                    end
`endif
                end

                ARB_DONE: state <= ARB_IDLE;

                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// tb_mesm6_mem_arbiter
// Drives three requester agents and a memory responder into the arbiter and
// compares every cycle against a transaction-level reference model: a free
// arbiter grants the round-robin winner, the granted operation stays on the
// memory bus until acked, the winner sees one done cycle, and one idle cycle
// separates that done from the next grant. Directed cases cover the basic
// read, a long write, three-way fairness, reset mid-transaction and the
// optional timeout.
module tb_mesm6_mem_arbiter;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 48;
    localparam int TB_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ibus_fetch;
    logic [ADDR_W-1:0] ibus_addr;
    logic [DATA_W-1:0] ibus_input;
    logic              ibus_done;
    logic              dbus_read;
    logic              dbus_write;
    logic [ADDR_W-1:0] dbus_addr;
    logic [DATA_W-1:0] dbus_output;
    logic [DATA_W-1:0] dbus_input;
    logic              dbus_done;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_done;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
`ifdef MESM6_ARB_TIMEOUT_EN
    logic              bus_error;
`endif

    always #5 clk = ~clk;

    mesm6_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ibus_fetch  (ibus_fetch),
        .ibus_addr   (ibus_addr),
        .ibus_input  (ibus_input),
        .ibus_done   (ibus_done),
        .dbus_read   (dbus_read),
        .dbus_write  (dbus_write),
        .dbus_addr   (dbus_addr),
        .dbus_output (dbus_output),
        .dbus_input  (dbus_input),
        .dbus_done   (dbus_done),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_rdata   (ext_rdata),
        .ext_done    (ext_done),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
`ifdef MESM6_ARB_TIMEOUT_EN
        ,
        .bus_error   (bus_error)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester agents: index 0 = dbus, 1 = ibus, 2 = ext.
    bit                ag_on[3];
    bit                ag_we[3];
    bit                ag_both[3];
    bit                ag_hold[3];
    logic [ADDR_W-1:0] ag_addr[3];
    logic [DATA_W-1:0] ag_wdata[3];
    bit                ag_keep;
    bit                ag_random;

    // Memory responder.
    int                resp_lat;
    int                cur_lat;
    int                bus_cnt;
    bit                resp_rand;
    bit                resp_spur;
    logic [DATA_W-1:0] resp_data;

    // Reference model.
    int                m_owner;
    int                m_ptr;
    int                m_done;
    int                m_bus_cycles;
    bit                m_cool;
    bit                m_we;
    bit                m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rd[3];

    // Operation each requester presented during the cycle just ended.
    logic [ADDR_W-1:0] s_addr[3];
    logic [DATA_W-1:0] s_wd[3];
    bit                s_we[3];

    function automatic logic [DATA_W-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    function automatic int rr_winner(input int last, input bit [2:0] rq);
        for (int k = 1; k <= 3; k++) begin
            if (rq[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic apply();
        dbus_read   = ag_on[0] && (!ag_we[0] || ag_both[0]);
        dbus_write  = ag_on[0] && ag_we[0];
        dbus_addr   = ag_addr[0];
        dbus_output = ag_wdata[0];
        ibus_fetch  = ag_on[1];
        ibus_addr   = ag_addr[1];
        ext_req     = ag_on[2];
        ext_we      = ag_we[2];
        ext_addr    = ag_addr[2];
        ext_wdata   = ag_wdata[2];
    endtask

    task automatic clear_agents();
        for (int k = 0; k < 3; k++) begin
            ag_on[k]    = 1'b0;
            ag_we[k]    = 1'b0;
            ag_both[k]  = 1'b0;
            ag_hold[k]  = 1'b0;
            ag_addr[k]  = '0;
            ag_wdata[k] = '0;
        end
    endtask

    task automatic new_txn(input int k);
        ag_on[k]    = 1'b1;
        ag_addr[k]  = ADDR_W'($urandom);
        ag_we[k]    = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        ag_both[k]  = (k == 0) && ag_we[k] && ($urandom_range(0, 1) == 1);
        ag_wdata[k] = rand_word();
    endtask

    // One clock: sample the inputs of the cycle, advance the model on the
    // edge, then compare the DUT outputs with the model.
    task automatic step();
        bit                r;
        bit                ak;
        bit                expired;
        bit [2:0]          rq;
        logic [DATA_W-1:0] rd;
        int                w;
        r  = reset;
        ak = mem_ack;
        rd = mem_rdata;
        rq = {ext_req, ibus_fetch, dbus_read | dbus_write};
        s_addr[0] = dbus_addr; s_we[0] = dbus_write; s_wd[0] = dbus_output;
        s_addr[1] = ibus_addr; s_we[1] = 1'b0;       s_wd[1] = '0;
        s_addr[2] = ext_addr;  s_we[2] = ext_we;     s_wd[2] = ext_wdata;

        @(posedge clk);
        #1;

        if (r) begin
            m_owner = -1; m_cool = 1'b0; m_ptr = 2; m_done = -1; m_err = 1'b0;
            for (int k = 0; k < 3; k++) m_rd[k] = '0;
        end else begin
            m_done = -1;
            if (m_owner >= 0) begin
                expired = 1'b0;
                if (!ak) begin
                    m_bus_cycles++;
`ifdef MESM6_ARB_TIMEOUT_EN
                    expired = (m_bus_cycles >= TB_TIMEOUT);
`endif
                end
                if (ak || expired) begin
                    if (!m_we) m_rd[m_owner] = ak ? rd : '0;
                    if (expired) m_err = 1'b1;
                    m_done  = m_owner;
                    m_ptr   = m_owner;
                    m_owner = -1;
                    m_cool  = 1'b1;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else begin
                w = rr_winner(m_ptr, rq);
                if (w >= 0) begin
                    m_owner      = w;
                    m_addr       = s_addr[w];
                    m_we         = s_we[w];
                    m_wdata      = s_wd[w];
                    m_bus_cycles = 0;
                end
            end
        end

        check("mem_read", mem_read, (m_owner >= 0) && !m_we);
        check("mem_write", mem_write, (m_owner >= 0) && m_we);
        if (m_owner >= 0) check("mem_addr", mem_addr, m_addr);
        if (m_owner >= 0 && m_we) check("mem_wdata", mem_wdata, m_wdata);
        check("dbus_done", dbus_done, m_done == 0);
        check("ibus_done", ibus_done, m_done == 1);
        check("ext_done", ext_done, m_done == 2);
        check("dbus_input", dbus_input, m_rd[0]);
        check("ibus_input", ibus_input, m_rd[1]);
        check("ext_rdata", ext_rdata, m_rd[2]);
`ifdef MESM6_ARB_TIMEOUT_EN
        check("bus_error", bus_error, m_err);
`endif
    endtask

    // Agents hold a request through its done cycle (like the core does) and
    // drop it on the following cycle.
    task automatic agents();
        if (ag_keep) return;
        for (int k = 0; k < 3; k++) begin
            if (ag_on[k] && m_done == k) begin
                ag_hold[k] = 1'b1;
            end else if (ag_hold[k]) begin
                ag_on[k]   = 1'b0;
                ag_hold[k] = 1'b0;
            end else if (ag_random) begin
                if (!ag_on[k]) begin
                    if ($urandom_range(0, 3) == 0) new_txn(k);
                end else if (m_owner != k && $urandom_range(0, 15) == 0) begin
                    ag_on[k] = 1'b0;   // withdraw while waiting
                end
            end
        end
    endtask

    task automatic responder();
        if (mem_read || mem_write) begin
            if (bus_cnt == 0) cur_lat = resp_rand ? int'($urandom_range(0, 3)) : resp_lat;
            mem_ack   = (cur_lat >= 0) && (bus_cnt == cur_lat);
            mem_rdata = resp_rand ? rand_word() : resp_data;
            bus_cnt++;
        end else begin
            bus_cnt   = 0;
            mem_ack   = resp_spur && ($urandom_range(0, 3) == 0);
            mem_rdata = rand_word();
        end
    endtask

    task automatic cycle();
        step();
        agents();
        responder();
        apply();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_agents();
        apply();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    int done_at;
    int ack_at;
    int cnt;
    int first;
    int n_done;
    int order[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        ag_keep   = 1'b0;
        ag_random = 1'b0;
        resp_lat  = 0;
        resp_rand = 1'b0;
        resp_spur = 1'b0;
        resp_data = '0;
        bus_cnt   = 0;
        cur_lat   = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        clear_agents();
        apply();

        // Reset state.
        do_reset();
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_strobes", {mem_read, mem_write}, 0);
        check("rst_done", {dbus_done, ibus_done, ext_done}, 0);

        // Instruction fetch with zero-latency ack.
        resp_lat   = 0;
        resp_data  = 48'h1234_5678_9ABC;
        ag_on[1]   = 1'b1;
        ag_addr[1] = 15'h0010;
        apply();
        done_at = 0;
        cnt     = 0;
        for (int j = 1; j <= 6; j++) begin
            cycle();
            if (ibus_done && done_at == 0) done_at = j + 1;
            if (mem_read) cnt++;
        end
        check("t1_done_cycle", done_at, 3);
        check("t1_read_cycles", cnt, 1);
        check("t1_ibus_input", ibus_input, 48'h1234_5678_9ABC);

        // Data write with ack on the fifth BUS cycle.
        resp_lat    = 4;
        ag_on[0]    = 1'b1;
        ag_we[0]    = 1'b1;
        ag_addr[0]  = 15'h7FFF;
        ag_wdata[0] = 48'hFFFF_FFFF_FFFF;
        apply();
        done_at = 0;
        ack_at  = 0;
        cnt     = 0;
        for (int j = 1; j <= 10; j++) begin
            cycle();
            if (mem_write) cnt++;
            if (dbus_done && done_at == 0) done_at = j;
            if (mem_ack && ack_at == 0) ack_at = j;
        end
        check("t2_write_cycles", cnt, 5);
        check("t2_ack_cycle", ack_at, 5);
        check("t2_done_after_ack", done_at, ack_at + 1);
        check("t2_dbus_input", dbus_input, 0);

        // All three requesters held continuously: strict rotation.
        do_reset();
        ag_keep = 1'b1;
        resp_lat = 0;
        ag_on[0] = 1'b1; ag_addr[0] = 15'h0101;
        ag_on[1] = 1'b1; ag_addr[1] = 15'h0202;
        ag_on[2] = 1'b1; ag_addr[2] = 15'h0303; ag_we[2] = 1'b1; ag_wdata[2] = 48'h0000_0000_5A5A;
        apply();
        order.delete();
        for (int j = 1; j <= 18; j++) begin
            cycle();
            if (dbus_done) order.push_back(0);
            if (ibus_done) order.push_back(1);
            if (ext_done)  order.push_back(2);
        end
        check("t3_ndone", order.size(), 6);
        for (int i = 0; i < order.size(); i++) check("t3_order", order[i], i % 3);
        ag_keep = 1'b0;

        // Reset in the second BUS cycle of an ext read.
        do_reset();
        resp_lat   = -1;
        ag_on[2]   = 1'b1;
        ag_addr[2] = 15'h0155;
        apply();
        cycle();
        cycle();
        check("t4_bus_before_reset", mem_read, 1);
        reset      = 1'b1;
        ag_on[0]   = 1'b1;
        ag_addr[0] = 15'h0022;
        apply();
        cycle();
        check("t4_strobes_after_reset", {mem_read, mem_write}, 0);
        check("t4_no_ext_done", ext_done, 0);
        reset     = 1'b0;
        resp_lat  = 0;
        resp_data = 48'hA5A5_0F0F_3C3C;
        apply();
        first = -1;
        for (int j = 1; j <= 10; j++) begin
            cycle();
            if (first < 0) begin
                if (dbus_done) first = 0;
                else if (ibus_done) first = 1;
                else if (ext_done) first = 2;
            end
        end
        check("t4_first_grant", 64'(first), 0);

        // Randomized traffic with random latency and stray acks.
        do_reset();
        resp_rand = 1'b1;
        resp_spur = 1'b1;
        ag_random = 1'b1;
        n_done    = 0;
        for (int j = 0; j < 3000; j++) begin
            cycle();
            n_done += int'(dbus_done) + int'(ibus_done) + int'(ext_done);
        end
        ag_random = 1'b0;
        repeat (40) cycle();
        resp_spur = 1'b0;
        resp_rand = 1'b0;
        check("rand_activity", n_done > 200, 1);

`ifdef MESM6_ARB_TIMEOUT_EN
        // Timeout: an ibus read that is never acked.
        do_reset();
        resp_lat   = 0;
        resp_data  = 48'hABCD_EF01_2345;
        ag_on[1]   = 1'b1;
        ag_addr[1] = 15'h0040;
        apply();
        repeat (5) cycle();
        check("to_prior_ibus_input", ibus_input, 48'hABCD_EF01_2345);
        resp_lat   = -1;
        ag_on[1]   = 1'b1;
        ag_addr[1] = 15'h0041;
        apply();
        cnt     = 0;
        done_at = 0;
        for (int j = 1; j <= 15; j++) begin
            cycle();
            if (mem_read) cnt++;
            if (ibus_done && done_at == 0) done_at = j;
        end
        check("to_strobe_cycles", cnt, TB_TIMEOUT);
        check("to_done_cycle", done_at, TB_TIMEOUT + 1);
        check("to_ibus_input", ibus_input, 0);
        check("to_bus_error", bus_error, 1);
        repeat (5) cycle();
        check("to_bus_error_sticky", bus_error, 1);
        do_reset();
        check("to_bus_error_reset", bus_error, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mesm6_mem_arbiter.md
Name: mesm6_mem_arbiter

Overview:
- Shares one single-ported main-memory interface between three requesters: the CPU instruction bus (ibus), the CPU data bus (dbus) and an external loader/debug port (ext).
- Sits between mesm6_core and the memory controller.
- The core side presents the core's native level-request / one-cycle-done handshake unchanged, so the core needs no modification.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 48, data word width.
- TIMEOUT, 255, cycles to wait for mem_ack before abort. Used only with MESM6_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- ibus_fetch  in  1  instruction read request, level, held until ibus_done.
- ibus_addr  in  ADDR_W  instruction address.
- ibus_input  out  DATA_W  instruction word read.
- ibus_done  out  1  one-cycle completion pulse.
- dbus_read  in  1  data read request, level.
- dbus_write  in  1  data write request, level.
- dbus_addr  in  ADDR_W  data address.
- dbus_output  in  DATA_W  write data from core.
- dbus_input  out  DATA_W  data word read.
- dbus_done  out  1  one-cycle completion pulse.
- ext_req  in  1  external request, level.
- ext_we  in  1  1 = write, 0 = read.
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_rdata  out  DATA_W  external read data.
- ext_done  out  1  one-cycle completion pulse.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, any latency ≥0 cycles after strobe.
- bus_error  out  1  sticky timeout flag. Port present only with MESM6_ARB_TIMEOUT_EN.

Behaviour:
- States: IDLE, BUS, DONE.
- Reset value of every output is 0, and state returns to IDLE.
- Reset mid-transaction: strobes drop at the next edge, no done is issued, and the round-robin pointer returns to its reset value.
- IDLE:
  - If any request is active, pick a winner by round-robin in order dbus → ibus → ext, starting after the last granted requester. Reset pointer = ext, so dbus wins first.
  - Latch winner id, address, write data and operation; go to BUS.
  - If no request is active, stay in IDLE.
- dbus_read and dbus_write asserted together: treated as a write.
- BUS:
  - mem_read/mem_write, mem_addr and mem_wdata are driven from the latched registers only, never combinationally from inputs.
  - Strobes stay high until mem_ack.
  - On mem_ack: capture mem_rdata into the winner's read-data register (not on writes), update the pointer to the winner, go to DONE.
- DONE:
  - Pulse the winner's *_done for exactly one cycle; strobes are low; go to IDLE.
  - Requests are not sampled in DONE, because the core still shows the old request on that cycle.
- Minimum transaction is 3 cycles (IDLE grant, BUS with same-cycle ack, DONE). Back-to-back grants are separated by the DONE cycle.
- Read-data outputs are registered and hold their value until the next read for the same requester. They are valid in the done cycle and afterwards.
- mem_ack outside BUS is ignored.
- A request withdrawn while not granted loses its place; no state is kept for it.
- A granted request must stay asserted until done; the arbiter does not check this.

Optional Feature:
- Macro MESM6_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter is cleared on entry to BUS and increments each BUS cycle.
  - If it reaches TIMEOUT without mem_ack, strobes drop, read data is forced to 0, the winner's done is pulsed via DONE, and bus_error is set.
  - bus_error stays set until reset.
- Without the macro: no counter, no bus_error port, and BUS waits indefinitely.

Decomposition:
- Package mesm6_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_BUS, ARB_DONE);
  - the requester id enum (REQ_DBUS, REQ_IBUS, REQ_EXT);
  - the ARB_NREQ=3 constant.
- One sub-module is natural: mesm6_rr_pick, a combinational 3-way round-robin selector. Inputs are the request vector and last id; outputs are the grant id and a valid bit.

Test Plan:
- ibus_fetch, addr 0x0010, mem_ack in the first BUS cycle, rdata 0x123456789ABC → ibus_done pulses on cycle 3 with ibus_input=0x123456789ABC; mem_read high exactly 1 cycle.
- dbus_write addr 0x7FFF, data 0xFFFFFFFFFFFF, ack after 4 cycles → mem_write high 5 cycles with matching addr/data; dbus_done 1 cycle after ack; dbus_input unchanged.
- dbus, ibus and ext all held from reset, each ack 0-latency → grant order dbus, ibus, ext, dbus, …; each done exactly once per grant; requests not resampled in DONE.
- reset asserted in the second BUS cycle of an ext read → strobes 0 next cycle, ext_done never pulses; after release, dbus is granted first.
- With MESM6_ARB_TIMEOUT_EN and TIMEOUT=8, mem_ack never asserted → strobes drop after 8 BUS cycles, ibus_done pulses with ibus_input=0, bus_error=1 until reset.
